// File: rtl/i2s_tx_fifo_ser.sv
// Purpose : stereo sample FIFO + Philips I2S serialiser; BCK/WS derived from AMCLK_i by division.
// Latency : a frame written into an empty FIFO is loaded at the next 63->0 slot wrap; MSB leaves 2*BCK_DIV cycles later.
// Backpr. : none upstream; writes into a full FIFO are dropped (OVERFLOW_o), frame start on empty repeats/mutes (UNDERRUN_o).
//
// Ports:
//   AMCLK_i        audio master clock (sole clock)
//   ARST           async reset, active-high; deassertion expected synchronous to AMCLK_i
//   APDATA_LEFT_i  left sample, APDATA_RIGHT_i right sample, APDATA_VALID_i 1-cycle write strobe
//   ASCLK_o        I2S BCK, ASDATA_o serial data (changes on BCK fall), ALRCLK_o WS (0 = left)
//   FIFO_LEVEL_o   stored frames, UNDERRUN_o / OVERFLOW_o 1-cycle event pulses
// Build option: define I2S_TX_UNDERRUN_MUTE_EN to output a muted (all-zero) frame on underrun
//   instead of repeating the last frame.

module i2s_tx_fifo_ser #(
    parameter int DATA_BITS = 24,
    parameter int BCK_DIV   = 2,
    parameter int FIFO_AW   = 2
) (
    input  logic                 AMCLK_i,
    input  logic                 ARST,
    input  logic [DATA_BITS-1:0] APDATA_LEFT_i,
    input  logic [DATA_BITS-1:0] APDATA_RIGHT_i,
    input  logic                 APDATA_VALID_i,
    output logic                 ASCLK_o,
    output logic                 ASDATA_o,
    output logic                 ALRCLK_o,
    output logic [FIFO_AW:0]     FIFO_LEVEL_o,
    output logic                 UNDERRUN_o,
    output logic                 OVERFLOW_o
);

    localparam int               DEPTH    = 2**FIFO_AW;
    localparam int               DIV_W    = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
    localparam logic [5:0]       K_DB     = 6'(DATA_BITS);

    // Clock divider / slot counter
    logic [DIV_W-1:0]           r_div_cnt;
    logic                       r_bck;
    logic [5:0]                 r_k;
    logic                       r_ws;
    logic                       r_sd;

    // Frame currently being serialised
    logic [DATA_BITS-1:0]       r_left;
    logic [DATA_BITS-1:0]       r_right;

    // FIFO
    logic [2*DATA_BITS-1:0]     r_mem [DEPTH];
    logic [FIFO_AW:0]           r_wr_ptr;
    logic [FIFO_AW:0]           r_rd_ptr;
    logic [FIFO_AW:0]           r_level;
    logic                       r_unf;
    logic                       r_ovf;

    logic                       w_fall;
    logic                       w_wrap;
    logic                       w_empty;
    logic                       w_full;
    logic                       w_pop;
    logic                       w_push;
    logic [5:0]                 w_k_nxt;
    logic [DATA_BITS-1:0]       w_l_sh;
    logic [DATA_BITS-1:0]       w_r_sh;
    logic                       w_sd_nxt;
    logic [FIFO_AW:0]           w_level_nxt;
    logic [2*DATA_BITS-1:0]     w_rd_dat;

    // BCK falls when the divider reaches terminal count while BCK is high.
    assign w_fall  = r_bck && (r_div_cnt == DIV_LAST);
    assign w_wrap  = w_fall && (r_k == 6'd63);
    assign w_k_nxt = r_k + 6'd1;    // natural 6-bit wrap gives mod 64

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]) &&
                     (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]);

    // Pop is decided first, so a write landing on the pop cycle of a full FIFO
    // still fits. An empty FIFO never bypasses a same-cycle write to the output.
    assign w_pop    = w_wrap && !w_empty;
    assign w_push   = APDATA_VALID_i && (!w_full || w_pop);
    assign w_rd_dat = r_mem[r_rd_ptr[FIFO_AW-1:0]];

    // Bring the bit for the upcoming slot to the MSB position; shift amounts
    // are only meaningful inside the data windows selected below.
    assign w_l_sh = r_left  << (w_k_nxt - 6'd1);
    assign w_r_sh = r_right << (w_k_nxt - 6'd33);

    always_comb begin
        w_sd_nxt = 1'b0;
        if ((w_k_nxt >= 6'd1) && (w_k_nxt <= K_DB)) begin
            w_sd_nxt = w_l_sh[DATA_BITS-1];
        end else if ((w_k_nxt >= 6'd33) && (w_k_nxt <= (6'd32 + K_DB))) begin
            w_sd_nxt = w_r_sh[DATA_BITS-1];
        end
    end

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge AMCLK_i or posedge ARST) begin
        if (ARST) begin
            r_div_cnt <= '0;
            r_bck     <= 1'b0;
            r_k       <= 6'd63;
            r_ws      <= 1'b1;
            r_sd      <= 1'b0;
            r_left    <= '0;
            r_right   <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_unf     <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_unf <= 1'b0;
            r_ovf <= 1'b0;

            if (r_div_cnt == DIV_LAST) begin
                r_div_cnt <= '0;
                r_bck     <= ~r_bck;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end

            if (w_fall) begin
                r_k  <= w_k_nxt;
                r_ws <= w_k_nxt[5];     // slots 32..63 are the right channel
                r_sd <= w_sd_nxt;
            end

            if (w_wrap) begin
                if (!w_empty) begin
                    r_left   <= w_rd_dat[2*DATA_BITS-1:DATA_BITS];
                    r_right  <= w_rd_dat[DATA_BITS-1:0];
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end else begin
                    r_unf <= 1'b1;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
                    r_left  <= '0;
                    r_right <= '0;
`endif
                end
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end else if (APDATA_VALID_i) begin
                r_ovf <= 1'b1;
            end

            r_level <= w_level_nxt;
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge AMCLK_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= {APDATA_LEFT_i, APDATA_RIGHT_i};
        end
    end

    assign ASCLK_o      = r_bck;
    assign ASDATA_o     = r_sd;
    assign ALRCLK_o     = r_ws;
    assign FIFO_LEVEL_o = r_level;
    assign UNDERRUN_o   = r_unf;
    assign OVERFLOW_o   = r_ovf;

endmodule
